// File: rtl/stopwatch_counter_if.sv
//------------------------------------------------------------------------------
// Module      : stopwatch_counter_if
// Description : Button inputs and time outputs of the stopwatch counter.
//               master = button/display side, slave = stopwatch core.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface stopwatch_counter_if;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [19:0] value;
  logic        running;
  logic        overflow;

  modport master (
    output start_stop, clear, lap,
    input  value, running, overflow
  );

  modport slave (
    input  start_stop, clear, lap,
    output value, running, overflow
  );
endinterface

`default_nettype wire

// File: rtl/stopwatch_counter.sv
//------------------------------------------------------------------------------
// Module      : stopwatch_counter
// Description : Start/stop/clear stopwatch producing a binary centisecond
//               count (0..MAX_COUNT) for the MM:SS.cc display stage.
//               Clock is divided by CLK_HZ/TICK_HZ into a count tick.
//               Optional lap-freeze feature enabled by macro STOPWATCH_LAP_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module stopwatch_counter #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 100,
  parameter int MAX_COUNT = 599999
) (
  input  logic                clk,
  input  logic                rst_n,
  stopwatch_counter_if.slave  bus
);

  localparam int              DIV          = CLK_HZ / TICK_HZ;
  localparam int              PW           = $clog2(DIV);
  localparam logic [PW-1:0]   C_PRESC_LAST = PW'(DIV - 1);
  localparam logic [19:0]     C_MAX        = 20'(MAX_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  // Registered state
  state_t          r_state;
  logic [19:0]     r_count;
  logic [PW-1:0]   r_presc;
  logic            r_overflow;
  logic [19:0]     r_value;
  logic            r_running;
  logic            r_ss_q;
  logic            r_clr_q;

  // Next-state values
  state_t          w_state_n;
  logic [19:0]     w_count_n;
  logic [PW-1:0]   w_presc_n;
  logic            w_overflow_n;
  logic [19:0]     w_value_n;

  logic            w_ss_edge;
  logic            w_clr_edge;
  logic            w_tick;

  assign w_ss_edge  = bus.start_stop & ~r_ss_q;
  assign w_clr_edge = bus.clear      & ~r_clr_q;
  assign w_tick     = (r_state == ST_RUNNING) && (r_presc == C_PRESC_LAST);

`ifdef STOPWATCH_LAP_EN
  logic            r_lap_q;
  logic            r_hold;
  logic [19:0]     r_lap_count;
  logic            w_hold_n;
  logic [19:0]     w_lap_count_n;
  logic            w_lap_edge;

  assign w_lap_edge = bus.lap & ~r_lap_q;

  // Lap register, hold flag and lap edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_q     <= 1'b0;
      r_hold      <= 1'b0;
      r_lap_count <= '0;
    end else begin
      r_lap_q     <= bus.lap;
      r_hold      <= w_hold_n;
      r_lap_count <= w_lap_count_n;
    end
  end

  // Lap hold control: clear wins; a lap edge releases an active hold, or
  // captures the live count when running.
  always_comb begin
    w_hold_n      = r_hold;
    w_lap_count_n = r_lap_count;
    if (w_clr_edge) begin
      w_hold_n = 1'b0;
    end else if (w_lap_edge) begin
      if (r_hold) begin
        w_hold_n = 1'b0;
      end else if (r_state == ST_RUNNING) begin
        w_hold_n      = 1'b1;
        w_lap_count_n = r_count;
      end
    end
  end

  assign w_value_n = w_hold_n ? w_lap_count_n : w_count_n;
`else
  // Lap input is accepted but has no function in this build.
  logic w_unused_lap;
  assign w_unused_lap = bus.lap;
  assign w_value_n    = w_count_n;
`endif

  // State register, counter, prescaler and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_presc    <= '0;
      r_overflow <= 1'b0;
      r_value    <= '0;
      r_running  <= 1'b0;
      r_ss_q     <= 1'b0;
      r_clr_q    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_count    <= w_count_n;
      r_presc    <= w_presc_n;
      r_overflow <= w_overflow_n;
      r_value    <= w_value_n;
      r_running  <= (w_state_n == ST_RUNNING);
      r_ss_q     <= bus.start_stop;
      r_clr_q    <= bus.clear;
    end
  end

  // Next-state logic: clear overrides everything; a tick and a pause edge in
  // the same cycle both take effect (count increments, then pause).
  always_comb begin
    w_state_n    = r_state;
    w_count_n    = r_count;
    w_presc_n    = r_presc;
    w_overflow_n = r_overflow;
    if (w_clr_edge) begin
      w_state_n    = ST_IDLE;
      w_count_n    = '0;
      w_presc_n    = '0;
      w_overflow_n = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_presc_n = '0;
          if (w_ss_edge) w_state_n = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (w_tick) begin
            w_presc_n = '0;
            if (r_count == C_MAX) begin
              w_overflow_n = 1'b1;
              w_state_n    = ST_PAUSED;
            end else begin
              w_count_n = r_count + 20'd1;
            end
          end else begin
            w_presc_n = r_presc + PW'(1);
          end
          if (w_ss_edge) w_state_n = ST_PAUSED;
        end
        ST_PAUSED: begin
          // A saturated stopwatch can only be left through clear.
          if (w_ss_edge && !r_overflow) w_state_n = ST_RUNNING;
        end
        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.value    = r_value;
  assign bus.running  = r_running;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_stopwatch_counter
// Description : Testbench for stopwatch_counter (DIV = 10). dut_a uses the
//               full range, dut_s saturates at 12. Lap expectations follow
//               macro STOPWATCH_LAP_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  stopwatch_counter_if bus_a ();
  stopwatch_counter_if bus_s ();

  stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_COUNT(599999)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_COUNT(12)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  typedef struct {
    string name;
    bit    ss;
    bit    clr;
    bit    lap;
    int    cycles;
    int    value;
    bit    running;
    bit    ovf;
  } vec_t;

  typedef struct {
    string name;
    bit    sel_s;
    int    value;
    bit    running;
    bit    ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input bit sel_s, input int v,
                          input bit r, input bit o);
    exp_t e;
    e.name = name; e.sel_s = sel_s; e.value = v; e.running = r; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    int   av;
    bit   ar, ao;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_empty: got no expected entry, want one");
      return;
    end
    e  = sb.pop_front();
    av = e.sel_s ? int'(bus_s.value) : int'(bus_a.value);
    ar = e.sel_s ? bus_s.running     : bus_a.running;
    ao = e.sel_s ? bus_s.overflow    : bus_a.overflow;
    n_vec++;
    if (av != e.value || ar != e.running || ao != e.ovf) begin
      n_miss++;
      $display("FAIL %s: got value=%0d running=%0b overflow=%0b, want value=%0d running=%0b overflow=%0b",
               e.name, av, ar, ao, e.value, e.running, e.ovf);
    end
  endtask

  // One-cycle button pulse on the chosen bus, then check
  task automatic pulse(input bit sel_s, input bit ss, input bit clr, input bit lap,
                       input string name, input int v, input bit r, input bit o);
    push_exp(name, sel_s, v, r, o);
    if (sel_s) begin
      bus_s.start_stop = ss; bus_s.clear = clr; bus_s.lap = lap;
    end else begin
      bus_a.start_stop = ss; bus_a.clear = clr; bus_a.lap = lap;
    end
    step(1);
    bus_a.start_stop = 1'b0; bus_a.clear = 1'b0; bus_a.lap = 1'b0;
    bus_s.start_stop = 1'b0; bus_s.clear = 1'b0; bus_s.lap = 1'b0;
    pop_check();
  endtask

  task automatic wait_check(input bit sel_s, input int n, input string name,
                            input int v, input bit r, input bit o);
    push_exp(name, sel_s, v, r, o);
    step(n);
    pop_check();
  endtask

  // Watchdog: the bench must never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[13];
    vecs[0]  = '{"reset_state",   0, 0, 0,   1, 0, 0, 0};
    vecs[1]  = '{"start",         1, 0, 0,   1, 0, 1, 0};
    vecs[2]  = '{"pre_tick",      0, 0, 0,   9, 0, 1, 0};
    vecs[3]  = '{"first_tick",    0, 0, 0,   1, 1, 1, 0};
    vecs[4]  = '{"run_50",        0, 0, 0,  40, 5, 1, 0};
    vecs[5]  = '{"run_74",        0, 0, 0,  24, 7, 1, 0};
    vecs[6]  = '{"pause",         1, 0, 0,   1, 7, 0, 0};
    vecs[7]  = '{"paused_hold",   0, 0, 0, 100, 7, 0, 0};
    vecs[8]  = '{"resume",        1, 0, 0,   1, 7, 1, 0};
    vecs[9]  = '{"resume_4",      0, 0, 0,   4, 7, 1, 0};
    vecs[10] = '{"resume_5",      0, 0, 0,   1, 8, 1, 0};
    vecs[11] = '{"clr_and_ss",    1, 1, 0,   1, 0, 0, 0};
    vecs[12] = '{"idle_stays",    0, 0, 0,  30, 0, 0, 0};

    rst_n = 1'b0;
    bus_a.start_stop = 1'b0; bus_a.clear = 1'b0; bus_a.lap = 1'b0;
    bus_s.start_stop = 1'b0; bus_s.clear = 1'b0; bus_s.lap = 1'b0;
    step(3);
    wait_check(1'b1, 0, "reset_s", 0, 0, 0);
    rst_n = 1'b1;

    // Table-driven run / pause / resume / clear on dut_a
    foreach (vecs[k]) begin
      push_exp(vecs[k].name, 1'b0, vecs[k].value, vecs[k].running, vecs[k].ovf);
      bus_a.start_stop = vecs[k].ss;
      bus_a.clear      = vecs[k].clr;
      bus_a.lap        = vecs[k].lap;
      step(1);
      bus_a.start_stop = 1'b0; bus_a.clear = 1'b0; bus_a.lap = 1'b0;
      step(vecs[k].cycles - 1);
      pop_check();
    end

    // start_stop held high for 30 cycles gives exactly one toggle
    push_exp("held_ss_30", 1'b0, 2, 1, 0);
    bus_a.start_stop = 1'b1;
    step(30);
    pop_check();
    bus_a.start_stop = 1'b0;
    wait_check(1'b0, 10, "held_ss_release", 3, 1, 0);
    pulse(1'b0, 0, 1, 0, "clear_after_hold", 0, 0, 0);

    // Lap freeze (or plain tracking when the feature is off)
    pulse(1'b0, 1, 0, 0, "lap_start", 0, 1, 0);
    wait_check(1'b0, 200, "lap_pre", 20, 1, 0);
    pulse(1'b0, 0, 0, 1, "lap_capture", 20, 1, 0);
    wait_check(1'b0, 49, "lap_mid", LAP_ON ? 20 : 25, 1, 0);
    wait_check(1'b0, 50, "lap_count30", LAP_ON ? 20 : 30, 1, 0);
    pulse(1'b0, 0, 0, 1, "lap_release", 30, 1, 0);
    wait_check(1'b0, 10, "lap_after", 31, 1, 0);
    pulse(1'b0, 0, 1, 0, "lap_clear", 0, 0, 0);
    pulse(1'b0, 0, 0, 1, "lap_idle_ignored", 0, 0, 0);
    pulse(1'b0, 1, 0, 0, "restart", 0, 1, 0);
    wait_check(1'b0, 10, "restart_tick", 1, 1, 0);
    pulse(1'b0, 0, 1, 0, "restart_clear", 0, 0, 0);

    // Saturation on dut_s (MAX_COUNT = 12)
    pulse(1'b1, 1, 0, 0, "sat_start", 0, 1, 0);
    wait_check(1'b1, 129, "sat_at_max", 12, 1, 0);
    wait_check(1'b1, 1, "sat_hit", 12, 0, 1);
    wait_check(1'b1, 20, "sat_hold", 12, 0, 1);
    pulse(1'b1, 1, 0, 0, "sat_ss_ignored", 12, 0, 1);
    wait_check(1'b1, 20, "sat_ss_still", 12, 0, 1);
    pulse(1'b1, 0, 1, 0, "sat_clear", 0, 0, 0);
    pulse(1'b1, 1, 0, 0, "sat_restart", 0, 1, 0);
    wait_check(1'b1, 10, "sat_restart_tick", 1, 1, 0);

    // Asynchronous reset mid-run on dut_a
    pulse(1'b0, 1, 0, 0, "ar_start", 0, 1, 0);
    wait_check(1'b0, 400, "ar_run_40", 40, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    wait_check(1'b0, 0, "ar_async_a", 0, 0, 0);
    wait_check(1'b1, 0, "ar_async_s", 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    wait_check(1'b0, 5, "ar_after", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Upstream time source for the six-digit MM:SS.cc seven-segment display stage.
- Divides the system clock down to a 100 Hz centisecond tick and runs a start/stop/clear stopwatch.
- Presents elapsed time as a 20-bit binary centisecond count, 0..599999 (99:59.99), which the display stage splits into minutes, seconds and centiseconds.
- Inputs are debounced, synchronous button levels; the block detects their rising edges.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 100, count-increment rate in Hz. CLK_HZ/TICK_HZ must be an integer >= 2.
- MAX_COUNT, 599999, terminal centisecond value. Must be < 2^20.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_stop  input  1  debounced button level; each rising edge toggles run/pause.
- clear  input  1  debounced button level; a rising edge zeroes the stopwatch.
- lap  input  1  debounced button level; a rising edge toggles display freeze (see Optional Feature).
- value  output  20  centisecond count to the display stage; registered.
- running  output  1  1 while in RUNNING.
- overflow  output  1  sticky flag; set when the count saturates at MAX_COUNT.

Behaviour:
- Reset (rst_n=0, asynchronous). Applies immediately, including mid-run or mid-lap:
  - state=IDLE; count=0; prescaler=0; value=0; running=0; overflow=0; lap hold cleared; edge-detect registers=0.
- Edge detection:
  - Each button is registered once; edge = btn & ~btn_q.
  - A level held high produces exactly one edge.
  - An edge in cycle N affects state/outputs visible in cycle N+1.
- Prescaler:
  - Counts 0..DIV-1, where DIV = CLK_HZ/TICK_HZ, only while state=RUNNING.
  - tick=1 when prescaler=DIV-1 in RUNNING; the prescaler then wraps to 0.
  - Holds its value in PAUSED, so resuming does not lose the partial centisecond.
  - Zeroed in IDLE.
- Counter:
  - On tick, count <= count+1.
  - If count=MAX_COUNT on tick: count holds at MAX_COUNT, overflow<=1, state<=PAUSED.
  - value reflects the new count the cycle after the tick cycle.
- State machine:
  - IDLE: start_stop edge -> RUNNING.
  - RUNNING: start_stop edge -> PAUSED; saturation -> PAUSED.
  - PAUSED: start_stop edge -> RUNNING, unless overflow=1, in which case the edge is ignored and the state stays PAUSED.
  - Any state: clear edge -> IDLE with count=0, prescaler=0, overflow=0, lap hold released.
- Priority within one cycle:
  - clear > start_stop > lap.
  - clear and start_stop edges together: result is IDLE with count 0; start is not applied.
  - start_stop edge and tick in the same cycle while RUNNING: the count increments, then PAUSED.
- running = (state==RUNNING), registered with the state.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - lap edge while RUNNING and not held: snapshot the current count into the lap register; value shows the snapshot while count keeps advancing.
  - Next lap edge (any state) releases the hold: value=count from the following cycle.
  - lap edge in IDLE or PAUSED with no hold active: ignored.
  - clear or reset releases the hold.
  - Saturation while held: hold is kept and overflow still sets.
- Not defined: lap port remains but is ignored; value always equals count; no lap register is synthesized.

Test Plan:
- Reset then run: CLK_HZ=1000, TICK_HZ=100 (DIV=10). Deassert rst_n, pulse start_stop -> running=1 next cycle; value=1 after 10 cycles, value=5 after 50 cycles.
- Pause/resume mid-centisecond: run 25 cycles (value=2, prescaler=5), pause for 100 cycles -> value stays 2; resume -> value=3 exactly 5 cycles after running reasserts.
- Saturation: MAX_COUNT=12, run past it -> value holds 12, overflow=1, running=0; start_stop edge -> no change; clear edge -> value=0, overflow=0, state IDLE.
- Simultaneous clear+start_stop rising edges while RUNNING at value=7 -> next cycle value=0, running=0. Holding start_stop high for 30 cycles -> exactly one toggle.
- Async reset mid-run: value=40, drop rst_n between clock edges -> value=0, running=0, overflow=0 immediately, before the next clock edge.
- STOPWATCH_LAP_EN: lap edge at value=20 -> value stays 20 while the internal count reaches 30; second lap edge -> value=30 next cycle. Macro undefined: same stimulus -> value tracks count throughout.
